// File: rtl/mac_fifo_loader.sv
// rtl/mac_fifo_loader.sv - stream router and systolic read/MAC sequencer for the MAC/FIFO array
// Optional: MAC_FIFO_LOADER_AUTOCLR_EN adds a one-cycle CLEAR state driving mac_clr; otherwise mac_clr registers clr_in.
module mac_fifo_loader #(
  parameter int DIM    = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_data,
  output logic [DIM-1:0]    wren_a,
  output logic              wren_b,
  input  logic [DIM-1:0]    full_a,
  input  logic              full_b,
  input  logic [DIM-1:0]    empty_a,
  input  logic              empty_b,
  output logic [DIM-1:0]    rden_a,
  output logic              rden_b,
  output logic [DIM-1:0]    mac_en,
  output logic              mac_clr,
  input  logic              clr_in,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(DIM * DIM);
  localparam int RW = $clog2(DIM);
  localparam int TW = $clog2(2 * DIM + RD_LAT);
  localparam logic [CW-1:0] A_LAST = CW'(DIM * DIM - 1);
  localparam logic [CW-1:0] B_LAST = CW'(DIM - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);
  localparam logic [TW-1:0] D_LAST = TW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic            err_q, err_d;
  logic [DIM-1:0]  mac_pipe_q [RD_LAT];
  logic [DIM-1:0]  mac_pipe_d [RD_LAT];
  logic [DIM-1:0]  sched_a;
  logic            sched_b;
  logic            accept;
  logic [RW-1:0]   row;

  assign row = RW'(cnt_q / CW'(DIM));

  always_comb begin
    in_ready = 1'b0;
    wren_a   = '0;
    wren_b   = 1'b0;
    case (state_q)
      S_LOAD_A: in_ready = !full_a[row];
      S_LOAD_B: in_ready = !full_b;
      default:  in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    if (accept && state_q == S_LOAD_A) wren_a[row] = 1'b1;
    if (accept && state_q == S_LOAD_B) wren_b = 1'b1;
  end

  // Row i reads during the DIM-cycle window starting at t = i (systolic skew).
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      sched_a[i] = (state_q == S_COMPUTE) && (t_q >= TW'(i)) && (t_q < TW'(i + DIM));
    end
    sched_b = (state_q == S_COMPUTE) && (t_q < TW'(DIM));
  end

  assign rden_a = sched_a & ~empty_a;
  assign rden_b = sched_b & ~empty_b;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_d           = t_q;
    err_d         = err_q;
    mac_pipe_d[0] = rden_a;
    for (int k = 1; k < RD_LAT; k++) mac_pipe_d[k] = mac_pipe_q[k-1];
    if (((sched_a & empty_a) != '0) || (sched_b && empty_b)) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          cnt_d = '0;
          t_d   = '0;
`ifdef MAC_FIFO_LOADER_AUTOCLR_EN
          state_d = S_CLEAR;
`else
          state_d = S_LOAD_A;
`endif
        end
      end
      S_CLEAR: state_d = S_LOAD_A;
      S_LOAD_A: begin
        if (accept) begin
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          if (cnt_q == B_LAST) begin
            cnt_d   = '0;
            t_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (t_q == T_LAST) begin
          t_d     = '0;
          state_d = S_DRAIN;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (t_q == D_LAST) begin
          t_d     = '0;
          state_d = S_DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) mac_pipe_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      err_q   <= err_d;
      for (int k = 0; k < RD_LAT; k++) mac_pipe_q[k] <= mac_pipe_d[k];
    end
  end

`ifdef MAC_FIFO_LOADER_AUTOCLR_EN
  logic unused_clr_in;
  assign unused_clr_in = clr_in;
  assign mac_clr       = (state_q == S_CLEAR);
`else
  logic mac_clr_q, mac_clr_d;
  assign mac_clr_d = clr_in;
  always_ff @(posedge clk) begin
    if (rst) mac_clr_q <= 1'b0;
    else     mac_clr_q <= mac_clr_d;
  end
  assign mac_clr = mac_clr_q;
`endif

  assign fifo_data = in_data;
  assign mac_en    = mac_pipe_q[RD_LAT-1];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_mac_fifo_loader.sv
// tb/tb_mac_fifo_loader.sv - scoreboard bench for mac_fifo_loader (DIM=8, DATA_W=8, RD_LAT=1)
module tb_mac_fifo_loader;
`ifdef MAC_FIFO_LOADER_AUTOCLR_EN
  localparam int BASE = 90;
  localparam int LOAD_FIRST = 2;
  localparam logic CLR_AT_1 = 1'b1;
`else
  localparam int BASE = 89;
  localparam int LOAD_FIRST = 1;
  localparam logic CLR_AT_1 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, wren_b, full_b, empty_b, rden_b;
  logic       mac_clr, clr_in, busy, done, err;
  logic [7:0] in_data, fifo_data, wren_a, full_a, empty_a, rden_a, mac_en;

  mac_fifo_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fifo_data(fifo_data), .wren_a(wren_a), .wren_b(wren_b),
    .full_a(full_a), .full_b(full_b), .empty_a(empty_a), .empty_b(empty_b),
    .rden_a(rden_a), .rden_b(rden_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .clr_in(clr_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] en; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [7:0] ra; logic rb; logic [7:0] me; logic dn; logic [7:0] ea; } step_t;

  wr_t   wr_q[$];
  step_t seq_q[$];
  int    cyc = 0;
  int    nchk = 0;
  int    nerr = 0;
  logic  mon_en = 1'b0;
  logic [7:0] ra_tab [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (seq_q.size() > 0 && seq_q[0].cyc == cyc) empty_a = seq_q[0].ea;
    else empty_a = 8'h00;
  end

  wr_t   mw;
  step_t ms;
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (wren_a != 8'h00 || wren_b) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {55'd0, wren_b, wren_a}, 64'd0);
        end else begin
          mw = wr_q.pop_front();
          check("write_enable", {55'd0, wren_b, wren_a}, {55'd0, mw.en});
          check("write_data", {56'd0, fifo_data}, {56'd0, mw.d});
        end
      end
      if (seq_q.size() > 0 && seq_q[0].cyc == cyc) begin
        ms = seq_q.pop_front();
        check("compute_step", {46'd0, rden_a, rden_b, mac_en, done},
              {46'd0, ms.ra, ms.rb, ms.me, ms.dn});
      end else begin
        check("quiet_step", {46'd0, rden_a, rden_b, mac_en, done}, 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {25'd0, in_ready, wren_a, wren_b, rden_a, rden_b, mac_en, mac_clr, busy, done, err, fifo_data}, 64'd0);
  endtask

  // mode: 0 nominal, 1 backpressure on row 2, 2 stream gaps, 3 underflow on row 7, 4 abort at byte 30
  task automatic run_job(input int mode, input int exp_lat);
    int nb, s, acc_cyc, stall, to, d, dcyc;
    logic found;
    logic [7:0] prev_ra;
    step_t st;
    wr_t w;
    nb = 0; stall = 0; to = 0; acc_cyc = 0; found = 1'b0; dcyc = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (nb < 72 && to < 2000) begin
      if (mode == 4 && nb == 30) begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        return;
      end
      full_a = 8'h00;
      if (mode == 1 && nb == 16 && stall < 5) full_a[2] = 1'b1;
      d = cyc - s - LOAD_FIRST;
      in_valid = (mode == 2) ? (d >= 0 && (d % 2) == 1) : 1'b1;
      in_data = nb[7:0];
      #1;
      if (cyc == s + 1) begin
        check("mac_clr_first_cycle", {63'd0, mac_clr}, {63'd0, CLR_AT_1});
        check("err_cleared_by_start", {63'd0, err}, 64'd0);
      end
      if (mode == 1 && nb == 16 && stall < 5) begin
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        stall++;
      end
      if (in_valid && in_ready) begin
        w.en = (nb < 64) ? (9'd1 << (nb / 8)) : 9'h100;
        w.d  = nb[7:0];
        wr_q.push_back(w);
        nb++;
        if (nb == 72) begin
          acc_cyc = cyc;
          prev_ra = 8'h00;
          for (int t = 0; t < 17; t++) begin
            st.cyc = acc_cyc + 1 + t;
            st.ra = 8'h00; st.rb = 1'b0; st.me = prev_ra; st.dn = (t == 16); st.ea = 8'h00;
            if (t < 15) begin
              st.ra = ra_tab[t];
              st.rb = (t < 8);
              if (mode == 3 && t >= 7) begin
                st.ea = 8'h80;
                st.ra[7] = 1'b0;
              end
            end
            prev_ra = st.ra;
            seq_q.push_back(st);
          end
        end
      end
      @(negedge clk);
      to++;
    end
    in_valid = 1'b0; full_a = 8'h00;
    if (nb < 72) check("load_timeout", 64'(nb), 64'd72);
    for (int k = 0; k < 400 && !found; k++) begin
      #3;
      if (done === 1'b1) begin found = 1'b1; dcyc = cyc; end
      else @(negedge clk);
    end
    check("done_seen", {63'd0, found}, 64'd1);
    check("done_latency", 64'(dcyc - s), 64'(exp_lat));
    check("err_at_done", {63'd0, err}, (mode == 3) ? 64'd1 : 64'd0);
    @(negedge clk);
    #1;
    check("idle_after_done", {62'd0, busy, done}, 64'd0);
    check("writes_drained", 64'(wr_q.size()), 64'd0);
    check("schedule_drained", 64'(seq_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    full_a = 8'h00; full_b = 1'b0; empty_b = 1'b0; clr_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    mon_en = 1'b1;
`ifndef MAC_FIFO_LOADER_AUTOCLR_EN
    @(negedge clk);
    clr_in = 1'b1;
    #1;
    check("clr_in_not_yet", {63'd0, mac_clr}, 64'd0);
    @(negedge clk);
    clr_in = 1'b0;
    #1;
    check("clr_in_registered", {63'd0, mac_clr}, 64'd1);
    @(negedge clk);
    #1;
    check("clr_in_one_cycle", {62'd0, mac_clr, busy}, 64'd0);
`endif
    run_job(0, BASE);
    run_job(1, BASE + 5);
    run_job(2, BASE + 72);
    run_job(3, BASE);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", {63'd0, err}, 64'd1);
    run_job(0, BASE);
    run_job(4, 0);
    run_job(0, BASE);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
